// File: rtl/systolic_sequencer.sv
// systolic_sequencer
//   Control sequencer for the MAC systolic array. It walks every output tile
//   of an M x M product. The row-slice of A is the outer loop and the
//   column-slice of B is the inner loop. For each tile it does four things:
//     - issues M operand reads,
//     - waits DRAIN_CYC cycles for the array skew to flush,
//     - hands N1 result rows to the writeback port under ready/valid,
//     - moves on to the next tile.
//   Optional feature: define SEQ_PERF_CNT_EN to build the busy-cycle counter
//   behind cycle_count. Without it, cycle_count is tied to zero.

module systolic_sequencer #(
    parameter int N1        = 4,
    parameter int N2        = 4,
    parameter int M         = 8,
    parameter int DRAIN_CYC = N1 + N2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              rd_en,
    output logic [$clog2((M*M)/N1)-1:0]                       rd_addr_A,
    output logic [$clog2((M*M)/N2)-1:0]                       rd_addr_B,
    output logic                                              acc_clr,
    output logic                                              wb_valid,
    input  logic                                              wb_ready,
    output logic [$clog2(M)-1:0]                              wb_row,
    output logic [(($clog2(M/N2) > 0) ? $clog2(M/N2) : 1)-1:0] wb_col_slice,
    output logic                                              acc_shift,
    output logic [31:0]                                       cycle_count
);

    // Port widths, restated for internal use.
    localparam int ADDR_A_W = $clog2((M*M)/N1);
    localparam int ADDR_B_W = $clog2((M*M)/N2);
    localparam int ROW_W    = $clog2(M);
    localparam int COL_W    = ($clog2(M/N2) > 0) ? $clog2(M/N2) : 1;

    // Loop counter widths. Each is forced to at least one bit.
    localparam int A_CNT = M / N1;
    localparam int B_CNT = M / N2;
    localparam int A_W   = (A_CNT > 1)     ? $clog2(A_CNT)     : 1;
    localparam int B_W   = COL_W;
    localparam int K_W   = (M > 1)         ? $clog2(M)         : 1;
    localparam int D_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int R_W   = (N1 > 1)        ? $clog2(N1)        : 1;

    // Terminal counts for each loop.
    localparam logic [A_W-1:0] A_LAST = A_W'(A_CNT - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(B_CNT - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(M - 1);
    localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYC - 1);
    localparam logic [R_W-1:0] R_LAST = R_W'(N1 - 1);

    // Multipliers for the address and row arithmetic, sized to the result.
    localparam logic [ADDR_A_W-1:0] M_AA = ADDR_A_W'(M);
    localparam logic [ADDR_B_W-1:0] M_AB = ADDR_B_W'(M);
    localparam logic [ROW_W-1:0]    N1_R = ROW_W'(N1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [A_W-1:0] r_a, w_a_nxt;   // A row-slice index
    logic [B_W-1:0] r_b, w_b_nxt;   // B column-slice index
    logic [K_W-1:0] r_k, w_k_nxt;   // operand read index within a tile
    logic [D_W-1:0] r_d, w_d_nxt;   // drain cycle index
    logic [R_W-1:0] r_r, w_r_nxt;   // result row within a tile

    // State and loop-counter register; reset returns everything to IDLE/zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_d     <= '0;
            r_r     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_k     <= w_k_nxt;
            r_d     <= w_d_nxt;
            r_r     <= w_r_nxt;
        end
    end

    // Next-state/counter logic plus output decode.
    // Outputs depend only on registered state, except acc_shift, which follows wb_ready.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latches).
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_k_nxt      = r_k;
        w_d_nxt      = r_d;
        w_r_nxt      = r_r;
        busy         = 1'b0;
        done         = 1'b0;
        rd_en        = 1'b0;
        rd_addr_A    = '0;
        rd_addr_B    = '0;
        acc_clr      = 1'b0;
        wb_valid     = 1'b0;
        wb_row       = '0;
        wb_col_slice = '0;
        acc_shift    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_k_nxt     = '0;
                    w_d_nxt     = '0;
                    w_r_nxt     = '0;
                end
            end

            S_RUN: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                rd_addr_A = ADDR_A_W'(r_a) * M_AA + ADDR_A_W'(r_k);
                rd_addr_B = ADDR_B_W'(r_b) * M_AB + ADDR_B_W'(r_k);
                acc_clr   = (r_k == '0);
                if (r_k == K_LAST) begin
                    w_k_nxt     = '0;
                    w_d_nxt     = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end

            S_DRAIN: begin
                busy = 1'b1;
                if (r_d == D_LAST) begin
                    w_d_nxt     = '0;
                    w_r_nxt     = '0;
                    w_state_nxt = S_WB;
                end else begin
                    w_d_nxt = r_d + 1'b1;
                end
            end

            S_WB: begin
                busy         = 1'b1;
                wb_valid     = 1'b1;
                wb_row       = ROW_W'(r_a) * N1_R + ROW_W'(r_r);
                wb_col_slice = r_b;
                acc_shift    = wb_ready;
                if (wb_ready) begin
                    if (r_r == R_LAST) begin
                        w_r_nxt = '0;
                        w_k_nxt = '0;
                        if (r_b != B_LAST) begin
                            w_b_nxt     = r_b + 1'b1;
                            w_state_nxt = S_RUN;
                        end else if (r_a != A_LAST) begin
                            w_b_nxt     = '0;
                            w_a_nxt     = r_a + 1'b1;
                            w_state_nxt = S_RUN;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_r_nxt = r_r + 1'b1;
                    end
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_count;

    // Busy-cycle counter: clears when a start is accepted and counts every busy cycle.
    // It holds its value through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_cycle_count <= '0;
        end else if (busy) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer
//   Self-checking bench for systolic_sequencer.
//
//   Reference model: when a start is accepted, the model builds the whole
//   expected run as an ordered list of cycle slots:
//     - reads,
//     - drain cycles,
//     - writeback beats,
//     - one done slot.
//   Each cycle, the head slot gives the expected outputs. A writeback slot
//   stays at the head while wb_ready is low.
//
//   Literal expectations for the directed scenarios pin down the model's
//   timing and addressing.

module tb_systolic_sequencer;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [3:0]  rd_addr_A;
    logic [3:0]  rd_addr_B;
    logic        acc_clr;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_row;
    logic [0:0]  wb_col_slice;
    logic        acc_shift;
    logic [31:0] cycle_count;

    systolic_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr_A    (rd_addr_A),
        .rd_addr_B    (rd_addr_B),
        .acc_clr      (acc_clr),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_row       (wb_row),
        .wb_col_slice (wb_col_slice),
        .acc_shift    (acc_shift),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum int {K_READ, K_DRAIN, K_WB, K_DONE} kind_t;
    typedef struct {
        kind_t kind;
        int    addr_a;
        int    addr_b;
        bit    clr;
        int    row;
        int    col;
    } slot_t;

    slot_t plan[$];
    int    exp_cc    = 0;
    int    cyc       = 0;
    int    start_cyc = 0;
    int    done_cnt  = 0;
    int    done_rel  = -1;
    int    clr_rel[$];
    int    obs_a[$];
    int    obs_b[$];
    int    obs_row[$];
    int    obs_col[$];

    function automatic slot_t mk(kind_t k, int aa, int ab, bit c, int row, int col);
        slot_t s;
        s.kind   = k;
        s.addr_a = aa;
        s.addr_b = ab;
        s.clr    = c;
        s.row    = row;
        s.col    = col;
        return s;
    endfunction

    // Whole-run schedule for M=8, N1=N2=4, DRAIN_CYC=8: A slice outer, B slice inner.
    task automatic build_plan();
        plan.delete();
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) plan.push_back(mk(K_READ, a*8 + k, b*8 + k, k == 0, 0, 0));
                for (int d = 0; d < 8; d++) plan.push_back(mk(K_DRAIN, 0, 0, 1'b0, 0, 0));
                for (int r = 0; r < 4; r++) plan.push_back(mk(K_WB, 0, 0, 1'b0, a*4 + r, b));
            end
        end
        plan.push_back(mk(K_DONE, 0, 0, 1'b0, 0, 0));
    endtask

    // Compare process: checks every cycle against the head slot, then advances the model.
    initial begin : compare
        logic [5:0] exp_ctl;
        logic [7:0] exp_addr;
        logic [3:0] exp_wb;
        bit         head_busy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            exp_ctl   = '0;
            exp_addr  = '0;
            exp_wb    = '0;
            head_busy = 1'b0;
            if (plan.size() != 0) begin
                case (plan[0].kind)
                    K_READ: begin
                        exp_ctl   = {1'b1, 1'b0, 1'b1, plan[0].clr, 1'b0, 1'b0};
                        exp_addr  = {4'(plan[0].addr_a), 4'(plan[0].addr_b)};
                        head_busy = 1'b1;
                    end
                    K_DRAIN: begin
                        exp_ctl   = 6'b100000;
                        head_busy = 1'b1;
                    end
                    K_WB: begin
                        exp_ctl   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, wb_ready};
                        exp_wb    = {3'(plan[0].row), 1'(plan[0].col)};
                        head_busy = 1'b1;
                    end
                    default: exp_ctl = 6'b010000;
                endcase
            end
            check("ctl{busy,done,rd_en,acc_clr,wb_valid,acc_shift}",
                  {busy, done, rd_en, acc_clr, wb_valid, acc_shift}, exp_ctl);
            check("rd_addr{A,B}", {rd_addr_A, rd_addr_B}, exp_addr);
            check("wb{row,col_slice}", {wb_row, wb_col_slice}, exp_wb);
            check("cycle_count", cycle_count, PERF ? exp_cc : 0);

            // Observations used by the directed literal checks.
            if (rd_en && acc_clr) clr_rel.push_back(cyc - start_cyc);
            if (rd_en) begin
                obs_a.push_back(int'(rd_addr_A));
                obs_b.push_back(int'(rd_addr_B));
            end
            if (wb_valid && wb_ready) begin
                obs_row.push_back(int'(wb_row));
                obs_col.push_back(int'(wb_col_slice));
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end

            // Advance the model using the inputs that the next edge samples.
            if (head_busy) exp_cc++;
            if (rst) begin
                plan.delete();
                exp_cc = 0;
            end else if (plan.size() == 0) begin
                if (start) begin
                    build_plan();
                    start_cyc = cyc;
                    exp_cc    = 0;
                    done_cnt  = 0;
                    done_rel  = -1;
                    clr_rel.delete();
                    obs_a.delete();
                    obs_b.delete();
                    obs_row.delete();
                    obs_col.delete();
                end
            end else if (!(plan[0].kind == K_WB && !wb_ready)) begin
                void'(plan.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job. The start pulse is at relative cycle 0.
    //   bp_from/bp_len : window in which wb_ready is held low.
    //   n1/n2          : extra start pulses.
    //   rst_at         : cycle at which reset is pulsed (-1 for none).
    //   rnd            : randomise wb_ready and the extra start pulses.
    task automatic run_case(input int bp_from, input int bp_len, input int n1, input int n2,
                            input int rst_at, input bit rnd, input int limit);
        for (int c = 0; c < limit; c++) begin
            start    = (c == 0) || (c == n1) || (c == n2) || (rnd && c > 0 && $urandom_range(0, 7) == 0);
            wb_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= bp_from && c < bp_from + bp_len);
            rst      = (c == rst_at);
            tick();
            if (done_cnt > 0 || (rst_at >= 0 && c >= rst_at + 2)) break;
        end
        start    = 1'b0;
        wb_ready = 1'b1;
        rst      = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        wb_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", {busy, done, rd_en, acc_clr, wb_valid, acc_shift, rd_addr_A, rd_addr_B}, 0);

        // Nominal run with wb_ready held high.
        run_case(-1, 0, -1, -1, -1, 1'b0, 200);
        check("nom_done_cycle", done_rel, 81);
        check("nom_done_pulses", done_cnt, 1);
        check("nom_cycle_count", cycle_count, PERF ? 80 : 0);
        check("nom_acc_clr_count", clr_rel.size(), 4);
        for (int t = 0; t < 4 && t < clr_rel.size(); t++) check("nom_acc_clr_cycle", clr_rel[t], 1 + 20*t);
        check("nom_reads", obs_a.size(), 32);
        if (obs_a.size() == 32) begin
            for (int i = 0; i < 8; i++) begin
                check("tile10_addr_A", obs_a[16 + i], 8 + i);
                check("tile10_addr_B", obs_b[16 + i], i);
                check("tile11_addr_B", obs_b[24 + i], 8 + i);
            end
        end
        check("nom_wb_beats", obs_row.size(), 16);
        if (obs_row.size() == 16) begin
            for (int r = 0; r < 4; r++) begin
                check("tile11_wb_row", obs_row[12 + r], 4 + r);
                check("tile11_wb_col", obs_col[12 + r], 1);
            end
        end

        // Backpressure: wb_ready is low for the first 5 cycles of the first WB beat.
        run_case(17, 5, -1, -1, -1, 1'b0, 200);
        check("bp_done_cycle", done_rel, 86);
        check("bp_first_row", obs_row.size() > 0 ? obs_row[0] : -1, 0);

        // Start pulses while busy have no effect.
        run_case(-1, 0, 10, 50, -1, 1'b0, 200);
        check("busy_start_done_cycle", done_rel, 81);
        check("busy_start_done_pulses", done_cnt, 1);

        // Reset during the drain of the third tile, then a fresh run.
        run_case(-1, 0, -1, -1, 50, 1'b0, 200);
        check("rst_no_done", done_cnt, 0);
        check("rst_idle_busy", busy, 0);
        check("rst_cycle_count", cycle_count, 0);
        run_case(-1, 0, -1, -1, -1, 1'b0, 200);
        check("replay_first_addr_A", obs_a.size() > 0 ? obs_a[0] : -1, 0);
        check("replay_first_addr_B", obs_b.size() > 0 ? obs_b[0] : -1, 0);
        check("replay_done_cycle", done_rel, 81);

        // Randomised backpressure and stray start pulses.
        for (int n = 0; n < 6; n++) begin
            run_case(-1, 0, -1, -1, -1, 1'b1, 400);
            check("rnd_done_pulses", done_cnt, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
